zap_wb_ram_responder: RTL and testbench

//  Wishbone B3 responder (slave) backed by a word-wide synchronous RAM.

---
 rtl/zap_wb_ram_responder.sv | 101 ++++++++++
 tb/tb_zap_wb_ram_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/zap_wb_ram_responder.sv
// zap_wb_ram_responder: Wishbone B3 RAM responder with wait states and linear CTI bursts
module zap_wb_ram_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic [2:0]  i_wb_cti,
  input  logic [1:0]  i_wb_bte,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [31:0] o_wb_dat
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, BEAT, BURST} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [30:0] adr_q, adr_n;
  logic [2:0] cti_q, cti_n;
  logic [1:0] bte_q, bte_n;
  logic fire, bad, ack_n, err_n;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^i_wb_adr[1:0];
  assign idx = adr_q[AW-1:0];
  assign fire = (state == BEAT || state == BURST) && i_wb_cyc && i_wb_stb;
  assign bad = adr_q >= 31'(DEPTH) || (state == BEAT && cti_q == 3'b010 && bte_q != 2'b00);
  assign ack_n = fire && !bad;
  assign err_n = fire && bad;
  // next-state: latch request, count wait states, then walk the burst address
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    adr_n = adr_q;
    cti_n = cti_q;
    bte_n = bte_q;
    if (state != IDLE && !i_wb_cyc)
      state_n = IDLE;
    else
      case (state)
        IDLE:
          if (i_wb_cyc && i_wb_stb) begin
            adr_n = {1'b0, i_wb_adr[31:2]};
            cti_n = i_wb_cti;
            bte_n = i_wb_bte;
            cnt_n = 4'(WAIT_STATES - 1);
            state_n = WAIT_STATES == 0 ? BEAT : WAIT;
          end
        WAIT: begin
          cnt_n = cnt - 4'd1;
          state_n = cnt == 4'd0 ? BEAT : WAIT;
        end
        BEAT:
          if (i_wb_stb) begin
            adr_n = adr_q + 31'd1;
            state_n = cti_q == 3'b010 && bte_q == 2'b00 ? BURST : IDLE;
          end
        BURST:
          if (i_wb_stb) begin
            adr_n = adr_q + 31'd1;
            state_n = i_wb_cti == 3'b111 ? IDLE : BURST;
          end
        default: state_n = IDLE;
      endcase
  end
  // control state and registered ACK/ERR/read data
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      adr_q <= 31'd0;
      cti_q <= 3'd0;
      bte_q <= 2'd0;
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_wb_dat <= 32'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      adr_q <= adr_n;
      cti_q <= cti_n;
      bte_q <= bte_n;
      o_wb_ack <= ack_n;
      o_wb_err <= err_n;
      if (ack_n && !i_wb_we) o_wb_dat <= mem[idx];
    end
  end
  // RAM byte-lane writes on acknowledged write beats only
  always_ff @(posedge i_clk) begin
    if (ack_n && i_wb_we)
      for (int b = 0; b < 4; b++)
        if (i_wb_sel[b]) mem[idx][8*b +: 8] <= i_wb_dat[8*b +: 8];
  end
endmodule

// File: tb/tb_zap_wb_ram_responder.sv
// tb_zap_wb_ram_responder: scoreboard bench for the Wishbone RAM responder
module tb_zap_wb_ram_responder;
  localparam int DEPTH = 128;
  localparam int WS = 1;

  logic i_clk = 0, i_reset_n = 0;
  logic i_wb_cyc = 0, i_wb_stb = 0, i_wb_we = 0;
  logic [31:0] i_wb_adr = 0, i_wb_dat = 0;
  logic [3:0] i_wb_sel = 0;
  logic [2:0] i_wb_cti = 0;
  logic [1:0] i_wb_bte = 0;
  logic o_wb_ack, o_wb_err;
  logic [31:0] o_wb_dat;

  always #5 i_clk = ~i_clk;

  zap_wb_ram_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .i_wb_cti(i_wb_cti), .i_wb_bte(i_wb_bte),
    .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err), .o_wb_dat(o_wb_dat)
  );

  typedef struct {
    int          word;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        err;
  } exp_t;

  exp_t sb[$];
  logic [31:0] mdl [DEPTH];
  logic [31:0] last_rd = 0;
  logic [31:0] last_dat = 0;
  logic [31:0] wd [16];
  logic [3:0] ws [16];
  int n_chk = 0, n_fail = 0;
  int lat, gap, nresp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every ACK/ERR pops one expected beat; the model memory is updated on pop
  always @(negedge i_clk) begin : mon
    exp_t e;
    if (o_wb_ack || o_wb_err) begin
      chk("ack_err_exclusive", 32'(o_wb_ack & o_wb_err), 32'd0);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_resp: got ack=%b err=%b expected no response", o_wb_ack, o_wb_err);
      end else begin
        e = sb.pop_front();
        if (!e.err && !e.we) last_rd = mdl[e.word];
        if (!e.err && e.we)
          for (int b = 0; b < 4; b++)
            if (e.sel[b]) mdl[e.word][8*b +: 8] = e.dat[8*b +: 8];
        chk($sformatf("resp_kind w%0d", e.word), 32'({o_wb_ack, o_wb_err}), 32'({~e.err, e.err}));
        chk($sformatf("rd_dat w%0d", e.word), o_wb_dat, last_rd);
      end
    end
  end

  task automatic rnd(input logic full);
    for (int i = 0; i < 16; i++) begin
      wd[i] = $urandom;
      ws[i] = full ? 4'hf : 4'($urandom);
    end
  endtask

  task automatic present(input int word, input int k, input int n, input logic we, input logic [1:0] bte);
    exp_t e;
    i_wb_adr = 32'((word + k) * 4);
    i_wb_dat = wd[k];
    i_wb_sel = ws[k];
    i_wb_cti = n == 1 ? 3'b000 : (k == n - 1 ? 3'b111 : 3'b010);
    e.word = word + k;
    e.we = we;
    e.dat = wd[k];
    e.sel = ws[k];
    e.err = (word + k >= DEPTH) || (n > 1 && bte != 2'b00);
    sb.push_back(e);
  endtask

  // master: presents beat k once k responses have been seen; stb can be throttled; optional reset mid-burst
  task automatic xfer(input int word, input int n, input logic we, input logic [1:0] bte,
                      input int thr_at, input int thr_len, input int rst_at);
    int k, p, thr, cyc_n, exp_n;
    exp_n = (n > 1 && bte != 2'b00) ? 1 : n;
    k = 0; p = 0; thr = 0; cyc_n = 0; gap = 0; lat = -1;
    @(posedge i_clk); #1;
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = we; i_wb_bte = bte;
    present(word, 0, n, we, bte);
    forever begin
      @(negedge i_clk);
      cyc_n++;
      if (o_wb_ack || o_wb_err) begin
        if (k == 0) lat = cyc_n - 2;
        last_dat = o_wb_dat;
        k++;
      end else if (k > 0) gap++;
      if (k == exp_n) break;
      if (cyc_n > 200) begin
        chk("resp_timeout", 32'(k), 32'(exp_n));
        break;
      end
      if (k > p) begin
        p = k;
        present(word, k, n, we, bte);
      end
      i_wb_stb = !(k == thr_at && thr < thr_len);
      if (!i_wb_stb) thr++;
      if (k == rst_at) begin
        #1 i_reset_n = 0;
        #1;
        chk("rst_mid_ack", 32'({o_wb_ack, o_wb_err}), 32'd0);
        chk("rst_mid_dat", o_wb_dat, 32'd0);
        sb.delete();
        last_rd = 0;
        break;
      end
    end
    nresp = k;
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_cti = 0; i_wb_bte = 0;
    if (!i_reset_n) begin
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset_n = 1;
    end
  endtask

  task automatic abort_wait();
    int c = 0;
    @(posedge i_clk); #1;
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_adr = 32'h40; i_wb_cti = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_wb_cyc = 0; i_wb_stb = 0;
    repeat (5) begin
      @(negedge i_clk);
      if (o_wb_ack || o_wb_err) c++;
    end
    chk("abort_noack", 32'(c), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge i_clk);
    chk("reset_ack", 32'(o_wb_ack), 32'd0);
    chk("reset_err", 32'(o_wb_err), 32'd0);
    chk("reset_dat", o_wb_dat, 32'd0);
    i_reset_n = 1;
    for (int b = 0; b < DEPTH / 16; b++) begin
      rnd(1);
      xfer(b * 16, 16, 1, 2'b00, -1, 0, -1);
    end
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hf;
    xfer(16, 1, 1, 2'b00, -1, 0, -1);
    xfer(16, 1, 0, 2'b00, -1, 0, -1);
    chk("classic_latency", 32'(lat), 32'(WS + 1));
    chk("classic_data", last_dat, 32'hDEADBEEF);
    @(negedge i_clk);
    chk("classic_one_cycle", 32'(o_wb_ack), 32'd0);
    wd[0] = 32'h11223344; ws[0] = 4'hf;
    xfer(5, 1, 1, 2'b00, -1, 0, -1);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    xfer(5, 1, 1, 2'b00, -1, 0, -1);
    xfer(5, 1, 0, 2'b00, -1, 0, -1);
    chk("byte_write", last_dat, 32'h11BB33DD);
    xfer(64, 16, 0, 2'b00, -1, 0, -1);
    chk("fill_beats", 32'(nresp), 32'd16);
    chk("fill_gap", 32'(gap), 32'd0);
    @(negedge i_clk);
    chk("fill_tail", 32'(o_wb_ack), 32'd0);
    xfer(64, 16, 0, 2'b00, 4, 2, -1);
    chk("throttle_beats", 32'(nresp), 32'd16);
    chk("throttle_gap", 32'(gap), 32'd2);
    rnd(0);
    xfer(32, 16, 1, 2'b00, 7, 1, -1);
    xfer(32, 16, 0, 2'b00, -1, 0, -1);
    rnd(1);
    xfer(DEPTH, 1, 1, 2'b00, -1, 0, -1);
    xfer(0, 1, 0, 2'b00, -1, 0, -1);
    xfer(8, 4, 0, 2'b01, -1, 0, -1);
    chk("bte_err_beats", 32'(nresp), 32'd1);
    xfer(DEPTH - 4, 8, 0, 2'b00, -1, 0, -1);
    chk("edge_burst_beats", 32'(nresp), 32'd8);
    rnd(0);
    xfer(DEPTH - 2, 4, 1, 2'b00, -1, 0, -1);
    xfer(DEPTH - 4, 4, 0, 2'b00, -1, 0, -1);
    abort_wait();
    rnd(1);
    xfer(80, 16, 1, 2'b00, -1, 0, 5);
    xfer(16, 1, 0, 2'b00, -1, 0, -1);
    chk("post_reset_latency", 32'(lat), 32'(WS + 1));
    chk("post_reset_data", last_dat, 32'hDEADBEEF);
    xfer(80, 16, 0, 2'b00, -1, 0, -1);
    for (int i = 0; i < 40; i++) begin
      int n, w;
      logic [1:0] bte;
      n = ($urandom_range(0, 2) == 0) ? 1 : int'($urandom_range(2, 8));
      w = int'($urandom_range(0, DEPTH + 3));
      bte = (n > 1 && $urandom_range(0, 7) == 0) ? 2'b01 : 2'b00;
      rnd(0);
      xfer(w, n, 1'($urandom), bte, int'($urandom_range(0, n)), int'($urandom_range(0, 2)), -1);
    end
    @(negedge i_clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
